// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM states, stage entries, depth bounds.
// Optional build macro FWD_EN (see pipe_hazard) changes only the hazard check.
package pipe_ctrl_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 8;
    localparam int REG_W_MAX = 8;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 wr_en;
        logic [REG_W_MAX-1:0] wr_reg;
        logic                 is_load;
    } stage_t;

    function automatic stage_t make_stage(
        input logic                 wr_en,
        input logic [REG_W_MAX-1:0] wr_reg,
        input logic                 is_load
    );
        stage_t s;
        s.valid   = 1'b1;
        s.wr_en   = wr_en;
        s.wr_reg  = wr_reg;
        s.is_load = is_load;
        return s;
    endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Scoreboard compare of decode sources against in-flight destinations.
// With FWD_EN defined only a load in stage 0 can cause a hazard.
module pipe_hazard
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int DEPTH = 3,
    localparam int RW   = $clog2(NREG)
) (
    input  stage_t [DEPTH-1:0] stg,
    input  logic               id_valid,
    input  logic               rs_used,
    input  logic               rt_used,
    input  logic [RW-1:0]      rs,
    input  logic [RW-1:0]      rt,
    output logic               hazard
);

    logic [REG_W_MAX-1:0] rs_x;
    logic [REG_W_MAX-1:0] rt_x;

    assign rs_x = REG_W_MAX'(rs);
    assign rt_x = REG_W_MAX'(rt);

    function automatic logic src_hit(
        input stage_t               s,
        input logic                 a_used,
        input logic [REG_W_MAX-1:0] a,
        input logic                 b_used,
        input logic [REG_W_MAX-1:0] b
    );
        return s.valid && s.wr_en &&
               ((a_used && s.wr_reg == a) || (b_used && s.wr_reg == b));
    endfunction

`ifdef FWD_EN
    // Bypass covers everything except data still coming back from memory.
    always_comb begin
        hazard = id_valid && stg[0].is_load &&
                 src_hit(stg[0], rs_used, rs_x, rt_used, rt_x);
    end
`else
    // WB stage is excluded: the register file writes before it reads.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (src_hit(stg[i], rs_used, rs_x, rt_used, rt_x)) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & id_valid;
    end
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: issue, hazard stall, branch flush, halt drain.
// Build option FWD_EN reduces the hazard check to load-use only.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int DEPTH = 3,
    parameter int CW    = 16,
    localparam int RW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic             id_wr_en,
    input  logic [RW-1:0]    id_wr_reg,
    input  logic             id_is_load,
    input  logic             id_halt,
    input  logic             br_taken,
    input  logic             mem_stall,
    output logic             stall,
    output logic             issue,
    output logic             flush,
    output logic [DEPTH-1:0] stg_valid,
    output logic             halted,
    output logic [CW-1:0]    stall_cnt,
    output logic             err
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("pipe_ctrl: DEPTH out of range");
    end

    state_t             state;
    state_t             state_nx;
    stage_t [DEPTH-1:0] stg;
    stage_t             entry;
    logic               hazard;
    logic               run;
    logic               hz_stall;

    pipe_hazard #(
        .NREG  (NREG),
        .DEPTH (DEPTH)
    ) u_hazard (
        .stg      (stg),
        .id_valid (id_valid),
        .rs_used  (id_rs_used),
        .rt_used  (id_rt_used),
        .rs       (id_rs),
        .rt       (id_rt),
        .hazard   (hazard)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stg_valid[i] = stg[i].valid;
        end
    end

    assign entry = make_stage(id_wr_en, REG_W_MAX'(id_wr_reg), id_is_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN: begin
                if (issue && id_halt) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (~|stg_valid) begin
                    state_nx = HALTED;
                end
            end
            HALTED: begin
                state_nx = HALTED;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    // Zero-latency controls; all forced low while reset is held.
    always_comb begin
        run      = (state == RUN);
        flush    = ~rst & br_taken & ~mem_stall;
        issue    = ~rst & run & id_valid & ~hazard & ~br_taken & ~mem_stall;
        stall    = ~rst & (mem_stall | ~run | (hazard & ~br_taken));
        hz_stall = run & hazard & ~br_taken & ~mem_stall;
    end

    assign halted = (state == HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg <= '0;
        end else if (!mem_stall) begin
            stg[0] <= issue ? entry : '0;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hz_stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // A taken branch must come from a real instruction in stage 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((br_taken && !stg[0].valid) ||
                     (id_valid && state == HALTED)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (DEPTH=3) plus a CW=4 copy for saturation.
// Expected stall counts depend on whether FWD_EN is defined.
module tb_pipe_ctrl;

`ifdef FWD_EN
    localparam int EXP_ADD  = 0;
    localparam int EXP_LOAD = 1;
    localparam logic [2:0] EXP_SAT_VALID = 3'b101;
`else
    localparam int EXP_ADD  = 2;
    localparam int EXP_LOAD = 2;
    localparam logic [2:0] EXP_SAT_VALID = 3'b001;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs_used, id_rt_used;
    logic [2:0]  id_rs, id_rt, id_wr_reg;
    logic        id_wr_en, id_is_load, id_halt;
    logic        br_taken, mem_stall;

    logic        stall, issue, flush, halted, err;
    logic [2:0]  stg_valid;
    logic [15:0] stall_cnt;

    logic        stall4, issue4, flush4, halted4, err4;
    logic [2:0]  stg_valid4;
    logic [3:0]  stall_cnt4;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.NREG(8), .DEPTH(3), .CW(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used), .id_rs(id_rs), .id_rt(id_rt),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .id_halt(id_halt),
        .br_taken(br_taken), .mem_stall(mem_stall),
        .stall(stall), .issue(issue), .flush(flush),
        .stg_valid(stg_valid), .halted(halted),
        .stall_cnt(stall_cnt), .err(err)
    );

    pipe_ctrl #(.NREG(8), .DEPTH(3), .CW(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used), .id_rs(id_rs), .id_rt(id_rt),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .id_halt(id_halt),
        .br_taken(br_taken), .mem_stall(mem_stall),
        .stall(stall4), .issue(issue4), .flush(flush4),
        .stg_valid(stg_valid4), .halted(halted4),
        .stall_cnt(stall_cnt4), .err(err4)
    );

    task automatic idle();
        id_valid = 0; id_rs_used = 0; id_rt_used = 0;
        id_rs = 0; id_rt = 0; id_wr_en = 0; id_wr_reg = 0;
        id_is_load = 0; id_halt = 0; br_taken = 0; mem_stall = 0;
    endtask

    task automatic drive(input int rsu, input int rs, input int rtu,
                         input int rt, input int we, input int wr,
                         input int ld, input int h);
        id_valid   = 1'b1;
        id_rs_used = rsu[0];
        id_rs      = 3'(rs);
        id_rt_used = rtu[0];
        id_rt      = 3'(rt);
        id_wr_en   = we[0];
        id_wr_reg  = 3'(wr);
        id_is_load = ld[0];
        id_halt    = h[0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts stall cycles until the held decode instruction issues.
    task automatic wait_issue(output int n, output bit ok);
        n = 0;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (issue) begin
                ok = 1;
                break;
            end
            if (stall) n++;
            @(negedge clk);
        end
        if (ok) @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        mem_stall = 1'b1;
        br_taken = 1'b1;
        id_valid = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL reset_stall got %b want 0", stall);
        end
        tests_run++;
        if (issue !== 1'b0 || flush !== 1'b0) begin
            fails++; $display("FAIL reset_issue_flush got %b%b want 00", issue, flush);
        end
        tests_run++;
        if (stg_valid !== 3'b000 || halted !== 1'b0) begin
            fails++; $display("FAIL reset_valid got %b/%b want 000/0", stg_valid, halted);
        end
        tests_run++;
        if (stall_cnt !== 16'd0 || err !== 1'b0) begin
            fails++; $display("FAIL reset_cnt_err got %0d/%b want 0/0", stall_cnt, err);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_v [6];
        exp_v[0] = 3'b001; exp_v[1] = 3'b011; exp_v[2] = 3'b111;
        exp_v[3] = 3'b110; exp_v[4] = 3'b100; exp_v[5] = 3'b000;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1, 6, 1, 7, 1, i + 1, 0, 0);
            else idle();
            #1;
            if (i < 3) begin
                tests_run++;
                if (issue !== 1'b1 || stall !== 1'b0) begin
                    fails++; $display("FAIL b2b_issue%0d got %b/%b want 1/0", i, issue, stall);
                end
            end
            @(negedge clk);
            tests_run++;
            if (stg_valid !== exp_v[i]) begin
                fails++; $display("FAIL b2b_valid%0d got %b want %b", i, stg_valid, exp_v[i]);
            end
        end
    endtask

    task automatic test_raw_hazard();
        int n;
        bit ok;
        do_reset();
        drive(1, 1, 1, 2, 1, 3, 0, 0);
        #1;
        tests_run++;
        if (issue !== 1'b1) begin
            fails++; $display("FAIL add_issue got %b want 1", issue);
        end
        @(negedge clk);
        drive(1, 3, 1, 4, 1, 5, 0, 0);
        wait_issue(n, ok);
        tests_run++;
        if (!ok || n != EXP_ADD) begin
            fails++; $display("FAIL add_use_stalls got %0d (ok=%0d) want %0d", n, ok, EXP_ADD);
        end
        tests_run++;
        if (stall_cnt !== 16'(EXP_ADD)) begin
            fails++; $display("FAIL add_use_cnt got %0d want %0d", stall_cnt, EXP_ADD);
        end
        drive(0, 0, 0, 0, 1, 3, 1, 0);
        @(negedge clk);
        drive(0, 0, 1, 3, 1, 6, 0, 0);
        wait_issue(n, ok);
        idle();
        tests_run++;
        if (!ok || n != EXP_LOAD) begin
            fails++; $display("FAIL load_use_stalls got %0d (ok=%0d) want %0d", n, ok, EXP_LOAD);
        end
        tests_run++;
        if (stall_cnt !== 16'(EXP_ADD + EXP_LOAD)) begin
            fails++; $display("FAIL load_use_cnt got %0d want %0d", stall_cnt, EXP_ADD + EXP_LOAD);
        end
    endtask

    task automatic test_branch_hazard();
        do_reset();
        drive(0, 0, 0, 0, 1, 3, 1, 0);
        @(negedge clk);
        drive(1, 3, 0, 0, 1, 4, 0, 0);
        br_taken = 1'b1;
        #1;
        tests_run++;
        if (flush !== 1'b1 || stall !== 1'b0 || issue !== 1'b0) begin
            fails++; $display("FAIL br_haz_ctl got f%b s%b i%b want f1 s0 i0", flush, stall, issue);
        end
        @(negedge clk);
        idle();
        tests_run++;
        if (stg_valid !== 3'b010 || stall_cnt !== 16'd0) begin
            fails++; $display("FAIL br_haz_state got %b/%0d want 010/0", stg_valid, stall_cnt);
        end
        tests_run++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL br_haz_err got %b want 0", err);
        end
        #1;
        tests_run++;
        if (flush !== 1'b0) begin
            fails++; $display("FAIL br_flush_drop got %b want 0", flush);
        end
    endtask

    task automatic test_branch_err();
        do_reset();
        br_taken = 1'b1;
        @(negedge clk);
        br_taken = 1'b0;
        @(negedge clk);
        tests_run++;
        if (err !== 1'b1) begin
            fails++; $display("FAIL br_empty_err got %b want 1", err);
        end
    endtask

    task automatic test_halt();
        int cyc;
        do_reset();
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 2, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        tests_run++;
        if (issue !== 1'b1 || stg_valid !== 3'b011) begin
            fails++; $display("FAIL halt_issue got %b/%b want 1/011", issue, stg_valid);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 5, 0, 0);
        #1;
        tests_run++;
        if (stall !== 1'b1 || issue !== 1'b0 || stg_valid !== 3'b111) begin
            fails++; $display("FAIL drain_ctl got s%b i%b v%b want s1 i0 v111", stall, issue, stg_valid);
        end
        idle();
        // DRAIN lasts while the halt walks out (3) plus the all-empty cycle.
        cyc = 0;
        for (int k = 0; k < 12; k++) begin
            if (halted) break;
            cyc++;
            @(negedge clk);
        end
        tests_run++;
        if (halted !== 1'b1 || cyc != 4) begin
            fails++; $display("FAIL drain_len got %0d cycles halted=%b want 4/1", cyc, halted);
        end
        tests_run++;
        if (stg_valid !== 3'b000 || err !== 1'b0) begin
            fails++; $display("FAIL halted_state got %b/%b want 000/0", stg_valid, err);
        end
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        #1;
        tests_run++;
        if (stall !== 1'b1 || issue !== 1'b0) begin
            fails++; $display("FAIL halted_ctl got s%b i%b want s1 i0", stall, issue);
        end
        @(negedge clk);
        idle();
        tests_run++;
        if (err !== 1'b1 || halted !== 1'b1) begin
            fails++; $display("FAIL halted_err got %b/%b want 1/1", err, halted);
        end
    endtask

    task automatic test_mem_stall();
        do_reset();
        drive(0, 0, 0, 0, 1, 3, 1, 0);
        @(negedge clk);
        drive(1, 3, 0, 0, 1, 4, 0, 0);
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (stall !== 1'b1 || issue !== 1'b0) begin
                fails++; $display("FAIL mstall_ctl%0d got s%b i%b want s1 i0", i, stall, issue);
            end
            @(negedge clk);
            tests_run++;
            if (stg_valid !== 3'b001 || stall_cnt !== 16'd0) begin
                fails++; $display("FAIL mstall_frz%0d got %b/%0d want 001/0", i, stg_valid, stall_cnt);
            end
        end
        mem_stall = 1'b0;
        @(negedge clk);
        idle();
        tests_run++;
        if (stg_valid !== 3'b010 || stall_cnt !== 16'd1) begin
            fails++; $display("FAIL mstall_release got %b/%0d want 010/1", stg_valid, stall_cnt);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        idle();
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            fails++; $display("FAIL drain_enter got %b want 1", stall);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (stg_valid !== 3'b000 || stall_cnt !== 16'd0 || halted !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL drain_rst got v%b c%0d h%b s%b want 000/0/0/0", stg_valid, stall_cnt, halted, stall);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        #1;
        tests_run++;
        if (issue !== 1'b1 || stall !== 1'b0) begin
            fails++; $display("FAIL post_rst_run got i%b s%b want i1 s0", issue, stall);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_saturation();
        int n;
        bit ok;
        do_reset();
        for (int p = 0; p < 20; p++) begin
            drive(0, 0, 0, 0, 1, 3, 1, 0);
            @(negedge clk);
            drive(0, 0, 1, 3, 1, 4, 0, 0);
            wait_issue(n, ok);
            if (p == 4) begin
                tests_run++;
                if (stall_cnt4 !== 4'(5 * EXP_LOAD)) begin
                    fails++; $display("FAIL sat_partial got %0d want %0d", stall_cnt4, 5 * EXP_LOAD);
                end
            end
        end
        idle();
        #1;
        tests_run++;
        if (stall_cnt4 !== 4'd15) begin
            fails++; $display("FAIL sat_cw4 got %0d want 15", stall_cnt4);
        end
        tests_run++;
        if (stall_cnt !== 16'(20 * EXP_LOAD)) begin
            fails++; $display("FAIL sat_cw16 got %0d want %0d", stall_cnt, 20 * EXP_LOAD);
        end
        tests_run++;
        if (stg_valid4 !== EXP_SAT_VALID || stg_valid !== EXP_SAT_VALID) begin
            fails++; $display("FAIL sat_valid got %b/%b want %b", stg_valid4, stg_valid, EXP_SAT_VALID);
        end
        tests_run++;
        if ({stall4, issue4, flush4, halted4, err4} !== 5'b00000) begin
            fails++; $display("FAIL sat_ctl4 got %b want 00000", {stall4, issue4, flush4, halted4, err4});
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (stall_cnt4 !== 4'd15) begin
            fails++; $display("FAIL sat_hold got %0d want 15", stall_cnt4);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_raw_hazard();
        test_branch_hazard();
        test_branch_err();
        test_halt();
        test_mem_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
